letter_entry_buffer: RTL

//   Upstream stage of the Caesar encryptor. Collects up to NUM_LETTERS letter codes from the

---
 rtl/letter_entry_buffer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/letter_entry_buffer.sv
// -----------------------------------------------------------------------------
// letter_entry_buffer
//   Upstream stage of the Caesar encryptor. Letter codes are entered from the
//   switches, one per pushbutton press, together with a shift amount taken
//   from the first letter of a word. Once the word is complete (buffer full,
//   or a 'go' pulse with at least one letter stored) the letters are streamed
//   to the encryptor as {shift, letter} bytes over a valid/ready handshake.
//
//   Optional feature macro: LETTER_ENTRY_DEBOUNCE_EN
//     defined     : the synchronised key must hold a new level for
//                   DEBOUNCE_CYCLES consecutive clocks before it is accepted.
//     not defined : the edge detector runs directly on the synchroniser output.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous, active-high reset
//   sw_in      in   [7:6] shift amount, [5:0] letter code, sampled on a press
//   key_n      in   raw active-low pushbutton, asynchronous to clk
//   go         in   1-cycle pulse: send the buffered (partial) word now
//   clear      in   synchronous abort: empty the buffer, return to FILL
//   out_data   out  {shift, letter} to the encryptor
//   out_valid  out  out_data holds a letter
//   out_ready  in   encryptor accepts; transfer = out_valid && out_ready
//   count      out  letters currently stored
//   full       out  count == NUM_LETTERS
//   done       out  1-cycle pulse after the last letter of a word is sent
// -----------------------------------------------------------------------------
module letter_entry_buffer #(
    parameter int NUM_LETTERS     = 6,
    parameter int LETTER_W        = 6,
    parameter int SHIFT_W         = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W          = $clog2(NUM_LETTERS + 1),
    localparam int DATA_W         = LETTER_W + SHIFT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              key_n,
    input  logic              go,
    input  logic              clear,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_FILL = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // The all-ones shift code is not a legal shift; it is pulled down by one.
    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0] r;
        if (s == {SHIFT_W{1'b1}}) begin
            r = s - SHIFT_W'(1);
        end else begin
            r = s;
        end
        return r;
    endfunction

    state_t              state_r, state_n;
    logic [CNT_W-1:0]    count_r, count_n;
    logic [CNT_W-1:0]    rd_ptr_r, rd_ptr_n;
    logic [CNT_W-1:0]    rd_next_s;
    logic [CNT_W-1:0]    post_count_s;
    logic [SHIFT_W-1:0]  shift_r, shift_n;
    logic [DATA_W-1:0]   out_data_r, out_data_n;
    logic                out_valid_r, out_valid_n;
    logic                done_r, done_n;
    logic                wr_en_s;
    logic [LETTER_W-1:0] first_letter_s;
    logic [LETTER_W-1:0] buf_r [NUM_LETTERS];

    logic key_meta_r, key_sync_r;
    logic key_level_s;
    logic key_prev_r;
    logic press_s;

    // Two-flop synchroniser for the raw pushbutton; idles at the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
        end else begin
            key_meta_r <= key_n;
            key_sync_r <= key_meta_r;
        end
    end

`ifdef LETTER_ENTRY_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] db_cnt_r;
    logic            db_level_r;

    // Debounce: accept a new key level only after it has persisted long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= 1'b1;
        end else if (key_sync_r == db_level_r) begin
            db_cnt_r   <= {DB_W{1'b0}};
        end else if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= key_sync_r;
        end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
        end
    end

    assign key_level_s = db_level_r;
`else
    assign key_level_s = key_sync_r;
`endif

    // Previous key level for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_prev_r <= 1'b1;
        end else begin
            key_prev_r <= key_level_s;
        end
    end

    // A press is the 1->0 transition of the clean key level; holding gives one pulse.
    assign press_s = key_prev_r & ~key_level_s;

    // Next-state and next-output computation for the FILL/SEND/DONE controller.
    always_comb begin
        state_n        = state_r;
        count_n        = count_r;
        rd_ptr_n       = rd_ptr_r;
        shift_n        = shift_r;
        out_data_n     = out_data_r;
        out_valid_n    = out_valid_r;
        done_n         = 1'b0;
        wr_en_s        = 1'b0;
        post_count_s   = count_r;
        first_letter_s = buf_r[0];
        rd_next_s      = rd_ptr_r + CNT_W'(1);

        if (clear) begin
            state_n     = ST_FILL;
            count_n     = {CNT_W{1'b0}};
            rd_ptr_n    = {CNT_W{1'b0}};
            out_valid_n = 1'b0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (press_s && (count_r < CNT_W'(NUM_LETTERS))) begin
                        wr_en_s      = 1'b1;
                        post_count_s = count_r + CNT_W'(1);
                        if (count_r == {CNT_W{1'b0}}) begin
                            shift_n        = clamp_shift(sw_in[DATA_W-1:LETTER_W]);
                            // The first letter is not in buf_r yet; forward it.
                            first_letter_s = sw_in[LETTER_W-1:0];
                        end else begin
                            shift_n        = shift_r;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                    count_n = post_count_s;
                    // A press and go together store the letter first, then send.
                    if ((post_count_s == CNT_W'(NUM_LETTERS)) ||
                        (go && (post_count_s != {CNT_W{1'b0}}))) begin
                        state_n     = ST_SEND;
                        rd_ptr_n    = {CNT_W{1'b0}};
                        out_valid_n = 1'b1;
                        out_data_n  = {shift_n, first_letter_s};
                    end else begin
                        state_n     = ST_FILL;
                    end
                end
                ST_SEND: begin
                    if (out_valid_r && out_ready) begin
                        if (rd_ptr_r == (count_r - CNT_W'(1))) begin
                            state_n     = ST_DONE;
                            out_valid_n = 1'b0;
                            done_n      = 1'b1;
                            count_n     = {CNT_W{1'b0}};
                            rd_ptr_n    = {CNT_W{1'b0}};
                        end else begin
                            rd_ptr_n    = rd_next_s;
                            out_data_n  = {shift_r, buf_r[rd_next_s]};
                        end
                    end else begin
                        state_n = ST_SEND;
                    end
                end
                ST_DONE: begin
                    state_n     = ST_FILL;
                    count_n     = {CNT_W{1'b0}};
                    rd_ptr_n    = {CNT_W{1'b0}};
                    out_valid_n = 1'b0;
                end
                default: begin
                    state_n     = ST_FILL;
                    count_n     = {CNT_W{1'b0}};
                    rd_ptr_n    = {CNT_W{1'b0}};
                    out_valid_n = 1'b0;
                end
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_FILL;
            count_r     <= {CNT_W{1'b0}};
            rd_ptr_r    <= {CNT_W{1'b0}};
            shift_r     <= {SHIFT_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            count_r     <= count_n;
            rd_ptr_r    <= rd_ptr_n;
            shift_r     <= shift_n;
            out_data_r  <= out_data_n;
            out_valid_r <= out_valid_n;
            done_r      <= done_n;
        end
    end

    // Letter storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[count_r] <= sw_in[LETTER_W-1:0];
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign done      = done_r;
    assign full      = (count_r == CNT_W'(NUM_LETTERS));

endmodule
